serial_ripple_subtractor: RTL and testbench

//  Multi-cycle ripple-borrow subtractor: Diff = A - B - Bin, computed DIGIT bits per clock

---
 rtl/arith_pkg.sv | 17 +
 rtl/full_subtractor.sv | 13 +
 rtl/serial_ripple_subtractor.sv | 109 ++++++++++
 tb/tb_serial_ripple_subtractor.sv | 180 ++++++++++++++++++
 4 files changed

// File: rtl/arith_pkg.sv
// Shared arithmetic-datapath definitions: FSM encoding and result-word width.
package arith_pkg;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RUN  = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  // Result-word width, shared with the ripple carry adder
  localparam int unsigned RESULT_W = 32;

  typedef enum logic [1:0] {
    StIdle = S_IDLE,
    StRun  = S_RUN,
    StDone = S_DONE
  } sub_state_e;

endpackage

// File: rtl/full_subtractor.sv
// One-bit full subtractor: d = a - b - bin, bout set when the bit borrows.
module full_subtractor (
  input  logic a,
  input  logic b,
  input  logic bin,
  output logic d,
  output logic bout
);

  assign d    = a ^ b ^ bin;
  assign bout = (~a & b) | (~(a ^ b) & bin);

endmodule

// File: rtl/serial_ripple_subtractor.sv
// Multi-cycle ripple-borrow subtractor: Diff = A - B - Bin, DIGIT bits per clock,
// borrow carried between digits in a register. Start/busy/done handshake.
module serial_ripple_subtractor
  import arith_pkg::*;
#(
  parameter int unsigned WIDTH = 16,
  parameter int unsigned DIGIT = 4
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  input  logic [WIDTH-1:0]   A,
  input  logic [WIDTH-1:0]   B,
  input  logic               Bin,
  output logic               busy,
  output logic               done,
  output logic [2*WIDTH-1:0] Diff,
  output logic               ov
);

  localparam int unsigned N    = WIDTH / DIGIT;
  localparam int unsigned CntW = (N > 1) ? $clog2(N) : 1;

  sub_state_e       state_q;
  logic [WIDTH-1:0] a_q;
  logic [WIDTH-1:0] b_q;
  logic [WIDTH-1:0] work_q;
  logic [WIDTH-1:0] work_d;
  logic             borrow_q;
  logic [CntW-1:0]  cnt_q;
  logic             last_digit;

  logic [DIGIT-1:0] dig_a;
  logic [DIGIT-1:0] dig_b;
  logic [DIGIT-1:0] dig_d;
  logic [DIGIT:0]   chain;

  // Select the current digit of each operand and splice the chain result into the work word
  always_comb begin
    dig_a      = a_q[cnt_q*DIGIT +: DIGIT];
    dig_b      = b_q[cnt_q*DIGIT +: DIGIT];
    work_d     = work_q;
    work_d[cnt_q*DIGIT +: DIGIT] = dig_d;
    last_digit = (cnt_q == CntW'(N - 1));
  end

  assign chain[0] = borrow_q;

  for (genvar i = 0; i < DIGIT; i++) begin : g_fs
    full_subtractor u_fs (
      .a    (dig_a[i]),
      .b    (dig_b[i]),
      .bin  (chain[i]),
      .d    (dig_d[i]),
      .bout (chain[i+1])
    );
  end

  // Control FSM with registered outputs; Diff/ov load only on the final digit
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= StIdle;
      a_q      <= '0;
      b_q      <= '0;
      work_q   <= '0;
      borrow_q <= 1'b0;
      cnt_q    <= '0;
      busy     <= 1'b0;
      done     <= 1'b0;
      Diff     <= '0;
      ov       <= 1'b0;
    end else begin
      done <= 1'b0;
      unique case (state_q)
        StIdle: begin
          if (start) begin
            a_q      <= A;
            b_q      <= B;
            borrow_q <= Bin;
            cnt_q    <= '0;
            work_q   <= '0;
            busy     <= 1'b1;
            state_q  <= StRun;
          end
        end
        StRun: begin
          work_q   <= work_d;
          borrow_q <= chain[DIGIT];
          cnt_q    <= last_digit ? '0 : cnt_q + CntW'(1);
          if (last_digit) begin
            state_q <= StDone;
            done    <= 1'b1;
            Diff    <= {{(WIDTH - 1){1'b0}}, chain[DIGIT], work_d};
            ov      <= (a_q[WIDTH-1] ^ b_q[WIDTH-1]) & (a_q[WIDTH-1] ^ work_d[WIDTH-1]);
          end
        end
        StDone: begin
          busy    <= 1'b0;
          state_q <= StIdle;
        end
        default: begin
          busy    <= 1'b0;
          state_q <= StIdle;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_serial_ripple_subtractor.sv
// Self-checking bench for serial_ripple_subtractor (WIDTH=16, DIGIT=4).
module tb_serial_ripple_subtractor;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic [15:0] A;
  logic [15:0] B;
  logic        Bin;
  logic        busy;
  logic        done;
  logic [31:0] Diff;
  logic        ov;

  int n_checks;
  int n_errors;

  serial_ripple_subtractor #(
    .WIDTH (16),
    .DIGIT (4)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .start (start),
    .A     (A),
    .B     (B),
    .Bin   (Bin),
    .busy  (busy),
    .done  (done),
    .Diff  (Diff),
    .ov    (ov)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h, expected %h", tag, obs, exp);
    end
  endtask

  // Reference: plain integer arithmetic on the operands
  function automatic logic [31:0] model_diff(input logic [15:0] a, input logic [15:0] b,
                                             input logic bin);
    int unsigned r;
    r = int'(a) - int'(b) - int'(bin);
    model_diff = {15'b0, (int'(a) < int'(b) + int'(bin)), r[15:0]};
  endfunction

  function automatic logic model_ov(input logic [15:0] a, input logic [15:0] b, input logic bin);
    int r;
    r = int'($signed(a)) - int'($signed(b)) - int'(bin);
    model_ov = (r > 32767) || (r < -32768);
  endfunction

  // One operation from an idle DUT; leaves the bench at the negedge after done
  task automatic run_op(input string tag, input logic [15:0] a, input logic [15:0] b,
                        input logic bin, input logic [31:0] exp_d, input logic exp_ov);
    int cyc;
    @(negedge clk);
    A = a; B = b; Bin = bin; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    A = $urandom; B = $urandom; Bin = 1'($urandom);
    cyc = 1;
    while (!done && cyc < 20) begin
      @(negedge clk);
      cyc++;
    end
    check({tag, ".latency"}, 32'(cyc), 32'd5);
    check({tag, ".diff"}, Diff, exp_d);
    check({tag, ".ov"}, 32'(ov), 32'(exp_ov));
    @(negedge clk);
    check({tag, ".done_pulse"}, 32'(done), 32'd0);
    check({tag, ".busy_after"}, 32'(busy), 32'd0);
    check({tag, ".diff_hold"}, Diff, exp_d);
  endtask

  initial begin
    logic [15:0] ra;
    logic [15:0] rb;
    logic        rbin;
    int          seen;
    int          last_done;
    n_checks = 0;
    n_errors = 0;
    rst_n = 1'b0; start = 1'b0; A = '0; B = '0; Bin = 1'b0;

    repeat (3) @(negedge clk);
    check("reset.busy", 32'(busy), 32'd0);
    check("reset.done", 32'(done), 32'd0);
    check("reset.diff", Diff, 32'h0);
    check("reset.ov", 32'(ov), 32'd0);
    rst_n = 1'b1;

    run_op("basic", 16'h0005, 16'h0003, 1'b0, 32'h0000_0002, 1'b0);
    run_op("borrow", 16'h0000, 16'h0001, 1'b0, 32'h0001_FFFF, 1'b0);
    run_op("ov_neg", 16'h8000, 16'h0001, 1'b0, 32'h0000_7FFF, 1'b1);
    run_op("ov_pos", 16'h7FFF, 16'hFFFF, 1'b0, 32'h0001_8000, 1'b1);
    run_op("ripple", 16'h1234, 16'h1234, 1'b1, 32'h0001_FFFF, 1'b0);

    // start while busy (cycles 2 and 5) must not disturb the running op
    @(negedge clk);
    A = 16'h0100; B = 16'h0001; Bin = 1'b0; start = 1'b1;
    @(negedge clk);                                     // cycle 1
    start = 1'b0;
    check("busy.run", 32'(busy), 32'd1);
    @(negedge clk);                                     // cycle 2
    A = 16'hAAAA; B = 16'h5555; Bin = 1'b1; start = 1'b1;
    @(negedge clk);                                     // cycle 3
    start = 1'b0;
    @(negedge clk);                                     // cycle 4
    check("ignore.no_early_done", 32'(done), 32'd0);
    @(negedge clk);                                     // cycle 5
    check("ignore.done", 32'(done), 32'd1);
    check("ignore.diff", Diff, 32'h0000_00FF);
    A = 16'h0F0F; B = 16'h0001; start = 1'b1;
    @(negedge clk);                                     // cycle 6
    start = 1'b0;
    check("ignore.idle", 32'(busy), 32'd0);
    @(negedge clk);
    check("ignore.no_relaunch", 32'(busy), 32'd0);
    check("ignore.diff_hold", Diff, 32'h0000_00FF);

    // reset mid-operation aborts without done
    @(negedge clk);
    A = 16'h4000; B = 16'h0001; Bin = 1'b0; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    #1 rst_n = 1'b0;
    #1;
    check("abort.busy", 32'(busy), 32'd0);
    check("abort.done", 32'(done), 32'd0);
    check("abort.diff", Diff, 32'h0);
    check("abort.ov", 32'(ov), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    seen = 0;
    repeat (8) begin
      @(negedge clk);
      if (done) seen++;
    end
    check("abort.no_done", 32'(seen), 32'd0);

    // start held high: back-to-back ops, done every 6 cycles
    @(negedge clk);
    A = 16'h1000; B = 16'h0001; Bin = 1'b1; start = 1'b1;
    seen = 0;
    last_done = -1;
    for (int c = 0; c < 40; c++) begin
      @(negedge clk);
      if (done) begin
        check("held.diff", Diff, 32'h0000_0FFE);
        if (last_done >= 0) check("held.period", 32'(c - last_done), 32'd6);
        last_done = c;
        seen++;
      end
    end
    check("held.count", 32'(seen >= 6), 32'd1);
    start = 1'b0;
    repeat (8) @(negedge clk);

    // randomized operands against the arithmetic reference
    for (int i = 0; i < 1000; i++) begin
      ra   = 16'($urandom);
      rb   = 16'($urandom);
      rbin = 1'($urandom);
      if (i % 10 == 0) rb = ra;
      run_op("rand", ra, rb, rbin, model_diff(ra, rb, rbin), model_ov(ra, rb, rbin));
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
